// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flop cells forming register q.
// Each accepted command drives per-bit J/K vectors for 1..16 clock steps.
module jk_bank_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [3:0]       cmd_count,
   output logic [WIDTH-1:0] jk_j,
   output logic [WIDTH-1:0] jk_k,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             busy,
   output logic             done,
   output logic             carry
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_HOLD   = 3'd0;
   localparam logic [2:0] OP_CLEAR  = 3'd1;
   localparam logic [2:0] OP_SET    = 3'd2;
   localparam logic [2:0] OP_LOAD   = 3'd3;
   localparam logic [2:0] OP_TOGGLE = 3'd4;
   localparam logic [2:0] OP_COUNT  = 3'd5;
   localparam logic [2:0] OP_SHIFT  = 3'd6;

   state_t           state;
   state_t           state_next;
   logic [2:0]       op;
   logic [WIDTH-1:0] data;
   logic [4:0]       rem;
   logic             accept;
   logic             run;

   // Ready is held low while reset is asserted so no handshake can be seen then.
   assign cmd_ready = (state == IDLE) & rst;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign accept    = cmd_valid & cmd_ready;
   assign qn        = ~q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    if (rem == 5'd1) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op   <= '0;
         data <= '0;
         rem  <= '0;
      end else if (accept) begin
         op   <= cmd_op;
         data <= cmd_data;
         rem  <= {1'b0, cmd_count} + 5'd1;
      end else if (state == EXEC) begin
         rem <= rem - 5'd1;
      end
   end

   // COUNT uses a ripple of prefix ANDs: a bit toggles when every lower bit is one.
   always_comb begin
      jk_j = '0;
      jk_k = '0;
      run  = 1'b1;
      if (state == EXEC) begin
         case (op)
            OP_CLEAR:  jk_k = '1;
            OP_SET:    jk_j = '1;
            OP_LOAD: begin
               jk_j = data;
               jk_k = ~data;
            end
            OP_TOGGLE: begin
               jk_j = data;
               jk_k = data;
            end
            OP_COUNT: begin
               for (int i = 0; i < WIDTH; i++) begin
                  jk_j[i] = run;
                  jk_k[i] = run;
                  run     = run & q[i];
               end
            end
            OP_SHIFT: begin
               jk_j = {q[WIDTH-2:0], data[0]};
               jk_k = ~{q[WIDTH-2:0], data[0]};
            end
            default: begin
               jk_j = '0;
               jk_k = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q     <= '0;
         carry <= 1'b0;
      end else begin
         q     <= (jk_j & ~q) | (~jk_k & q);
         carry <= (state == EXEC) && (op == OP_COUNT) && (&q);
      end
   end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl: directed table, handshake/reset
// corner sequences and randomized commands against a step-level model.
module tb_jk_bank_ctrl;

   localparam logic [7:0] ONES = 8'hFF;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data;
   logic [3:0] cmd_count;
   logic [7:0] jk_j;
   logic [7:0] jk_k;
   logic [7:0] q;
   logic [7:0] qn;
   logic       busy;
   logic       done;
   logic       carry;

   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [7:0] ref_q;
   logic       exp_carry;

   typedef struct {
      logic [2:0] op;
      logic [7:0] data;
      logic [3:0] count;
      logic [7:0] final_q;
   } vec_t;

   vec_t vecs [12];

   jk_bank_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
      .jk_j(jk_j), .jk_k(jk_k), .q(q), .qn(qn),
      .busy(busy), .done(done), .carry(carry)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %02h required %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Register value after one step of an operation, in plain arithmetic terms.
   function automatic logic [7:0] ref_next(input logic [2:0] op, input logic [7:0] d,
                                           input logic [7:0] cur);
      case (op)
         3'd1:    return 8'h00;
         3'd2:    return ONES;
         3'd3:    return d;
         3'd4:    return cur ^ d;
         3'd5:    return cur + 8'd1;
         3'd6:    return {cur[6:0], d[0]};
         default: return cur;
      endcase
   endfunction

   // Expected {j,k}; for COUNT the toggling bits are exactly those that change in q+1.
   function automatic logic [15:0] ref_jk(input logic [2:0] op, input logic [7:0] d,
                                          input logic [7:0] cur);
      logic [7:0] t;
      logic [7:0] s;
      t = (cur + 8'd1) ^ cur;
      s = {cur[6:0], d[0]};
      case (op)
         3'd1:    return {8'h00, ONES};
         3'd2:    return {ONES, 8'h00};
         3'd3:    return {d, ~d};
         3'd4:    return {d, d};
         3'd5:    return {t, t};
         3'd6:    return {s, ~s};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic exec_cmd(input logic [2:0] op, input logic [7:0] d,
                           input logic [3:0] cnt, input int abort_at);
      logic [15:0] jk;
      int          guard;
      guard = 0;
      while (!cmd_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check("accept_ready", 8'(cmd_ready), 8'd1);
      if (!cmd_ready) return;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      cmd_count = cnt;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_data  = 8'($urandom);
      cmd_count = 4'($urandom);
      exp_carry = 1'b0;
      for (int s = 0; s <= int'(cnt); s++) begin
         jk = ref_jk(op, d, ref_q);
         check("exec_busy", 8'(busy), 8'd1);
         check("exec_ready", 8'(cmd_ready), 8'd0);
         check("exec_done", 8'(done), 8'd0);
         check("exec_q", q, ref_q);
         check("exec_qn", qn, ~ref_q);
         check("exec_carry", 8'(carry), 8'(exp_carry));
         check("exec_j", jk_j, jk[15:8]);
         check("exec_k", jk_k, jk[7:0]);
         if (s == abort_at) return;
         exp_carry = (op == 3'd5) && (ref_q == ONES);
         ref_q     = ref_next(op, d, ref_q);
         @(negedge clk);
      end
      check("done_pulse", 8'(done), 8'd1);
      check("done_busy", 8'(busy), 8'd1);
      check("done_ready", 8'(cmd_ready), 8'd0);
      check("done_q", q, ref_q);
      check("done_carry", 8'(carry), 8'(exp_carry));
      @(negedge clk);
      check("idle_done", 8'(done), 8'd0);
      check("idle_ready", 8'(cmd_ready), 8'd1);
      check("idle_carry", 8'(carry), 8'd0);
      check("idle_j", jk_j, 8'h00);
      check("idle_q", q, ref_q);
   endtask

   initial begin
      vecs[0]  = '{3'd3, 8'hA5, 4'd0,  8'hA5};
      vecs[1]  = '{3'd3, 8'hFD, 4'd0,  8'hFD};
      vecs[2]  = '{3'd5, 8'h00, 4'd4,  8'h02};
      vecs[3]  = '{3'd3, 8'h0F, 4'd0,  8'h0F};
      vecs[4]  = '{3'd4, 8'h3C, 4'd2,  8'h33};
      vecs[5]  = '{3'd3, 8'h81, 4'd0,  8'h81};
      vecs[6]  = '{3'd6, 8'h01, 4'd3,  8'h1F};
      vecs[7]  = '{3'd1, 8'h5A, 4'd7,  8'h00};
      vecs[8]  = '{3'd2, 8'h00, 4'd1,  8'hFF};
      vecs[9]  = '{3'd0, 8'h12, 4'd5,  8'hFF};
      vecs[10] = '{3'd7, 8'h34, 4'd2,  8'hFF};
      vecs[11] = '{3'd5, 8'h00, 4'd0,  8'h00};

      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_data  = 8'h00;
      cmd_count = 4'd0;
      ref_q     = 8'h00;
      exp_carry = 1'b0;
      #2;
      check("rst_q", q, 8'h00);
      check("rst_qn", qn, ONES);
      check("rst_busy", 8'(busy), 8'd0);
      check("rst_done", 8'(done), 8'd0);
      check("rst_carry", 8'(carry), 8'd0);
      check("rst_jk", {jk_j[3:0], jk_k[3:0]}, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rel_ready", 8'(cmd_ready), 8'd1);

      for (int i = 0; i < 12; i++) begin
         exec_cmd(vecs[i].op, vecs[i].data, vecs[i].count, -1);
         check("table_final_q", q, vecs[i].final_q);
      end

      // cmd_valid stays high throughout a CLEAR; the second request waits for IDLE.
      cmd_valid = 1'b1;
      cmd_op    = 3'd1;
      cmd_data  = 8'h00;
      cmd_count = 4'd7;
      @(negedge clk);
      cmd_op    = 3'd3;
      cmd_data  = 8'h55;
      cmd_count = 4'd0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check("b2b_q", q, 8'h00);
         check("b2b_ready", 8'(cmd_ready), 8'd0);
         check("b2b_done", 8'(done), (k == 8) ? 8'd1 : 8'd0);
      end
      @(negedge clk);
      check("b2b_idle_ready", 8'(cmd_ready), 8'd1);
      check("b2b_idle_busy", 8'(busy), 8'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("b2b_second_busy", 8'(busy), 8'd1);
      check("b2b_second_j", jk_j, 8'h55);
      check("b2b_second_q0", q, 8'h00);
      @(negedge clk);
      check("b2b_second_q", q, 8'h55);
      check("b2b_second_done", 8'(done), 8'd1);
      @(negedge clk);
      ref_q = 8'h55;

      // Reset during a long COUNT: aborts with no done and clears the bank.
      exec_cmd(3'd3, 8'h00, 4'd0, -1);
      exec_cmd(3'd5, 8'h00, 4'd15, 6);
      rst = 1'b0;
      #1;
      check("abort_q", q, 8'h00);
      check("abort_busy", 8'(busy), 8'd0);
      check("abort_done", 8'(done), 8'd0);
      check("abort_j", jk_j, 8'h00);
      ref_q = 8'h00;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("abort_hold_done", 8'(done), 8'd0);
         check("abort_hold_q", q, 8'h00);
      end
      rst = 1'b1;
      #1;
      check("abort_rel_ready", 8'(cmd_ready), 8'd1);
      exec_cmd(3'd3, 8'h3C, 4'd0, -1);
      check("abort_load_q", q, 8'h3C);

      for (int n = 0; n < 40; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) @(negedge clk);
         exec_cmd(3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom_range(0, 6)), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
